// File: rtl/shreg_slot_sched_pkg.sv
// Shared definitions for the sha512crypt shreg slot scheduler: tag layout,
// parameter limits and the per-cycle pipeline action encoding.
package shreg_slot_sched_pkg;

  localparam int DEPTH_MIN  = 1;
  localparam int DEPTH_MAX  = 16;
  localparam int ROUNDS_MIN = 1;
  localparam int N_REQ_MAX  = 8;
  localparam int OCC_W      = 5;

  // Tag packing is {valid, id, round}; round sits in the low bits.
  localparam int TAG_RND_LSB = 0;

  function automatic int tag_id_lsb(input int rnd_w);
    return TAG_RND_LSB + rnd_w;
  endfunction

  function automatic int tag_vld_bit(input int id_w, input int rnd_w);
    return tag_id_lsb(rnd_w) + id_w;
  endfunction

  function automatic int tag_width(input int id_w, input int rnd_w);
    return tag_vld_bit(id_w, rnd_w) + 1;
  endfunction

  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_INJECT = 2'd2,
    ACT_RECIRC = 2'd3
  } sched_act_e;

endpackage

// File: rtl/shreg_slot_sched_if.sv
// Requester / consumer / shreg-control bundle of the slot scheduler.
interface shreg_slot_sched_if #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 3
) ();

  logic [N_REQ-1:0]                       req;
  logic [N_REQ*ID_W-1:0]                  req_id;
  logic [N_REQ-1:0]                       gnt;
  logic                                   shreg_en;
  logic                                   mux_sel;
  logic                                   done_valid;
  logic [ID_W-1:0]                        done_id;
  logic                                   done_rdy;
  logic [shreg_slot_sched_pkg::OCC_W-1:0] occupancy;
  logic                                   busy;

  modport master (
    output req, req_id, done_rdy,
    input  gnt, shreg_en, mux_sel, done_valid, done_id, occupancy, busy
  );

  modport slave (
    input  req, req_id, done_rdy,
    output gnt, shreg_en, mux_sel, done_valid, done_id, occupancy, busy
  );

endinterface

// File: rtl/shreg_slot_sched_rr_arbiter.sv
// One-hot round-robin arbiter; search starts at ptr and ptr moves past the
// winner only when a grant is actually issued.
module shreg_slot_sched_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gidx,
  output logic             any_gnt
);

  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] cand_s;

  // First requester at or after ptr wins.
  always_comb begin
    gnt     = '0;
    gidx    = '0;
    any_gnt = 1'b0;
    cand_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = IDX_W'((int'(ptr_r) + i) % N_REQ);
      if (en && !any_gnt && req[cand_s]) begin
        gnt[cand_s] = 1'b1;
        gidx        = cand_s;
        any_gnt     = 1'b1;
      end else begin
        any_gnt = any_gnt;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (any_gnt) begin
      ptr_r <= IDX_W'((int'(gidx) + 1) % N_REQ);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/shreg_slot_sched.sv
// Slot scheduler for the interleaved sha512crypt shreg pipeline: tracks a tag
// per slot, drives shreg enable / input mux, injects and retires contexts.
module shreg_slot_sched
  import shreg_slot_sched_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ROUNDS = 3,
  parameter int N_REQ  = 2,
  parameter int ID_W   = 3,
  parameter int RND_W  = 8
) (
  input logic               CLK,
  input logic               reset,
  shreg_slot_sched_if.slave bus
);

  localparam int TAG_W   = tag_width(ID_W, RND_W);
  localparam int ID_LSB  = tag_id_lsb(RND_W);
  localparam int VLD_BIT = tag_vld_bit(ID_W, RND_W);
  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

  logic [TAG_W-1:0] tag_r [DEPTH];
  logic [TAG_W-1:0] tail_s;
  logic [OCC_W-1:0] occ_r;

  logic             h_valid_s;
  logic [ID_W-1:0]  h_id_s;
  logic [RND_W-1:0] h_rnd_s;
  logic             final_s;
  logic             retire_s;
  logic             free_s;
  logic             arb_en_s;
  logic             any_gnt_s;
  logic [N_REQ-1:0] gnt_s;
  logic [IDX_W-1:0] gidx_s;
  logic [ID_W-1:0]  inj_id_s;
  logic             done_valid_s;
  sched_act_e       act_s;

  // The head tag lines up with the data shreg output.
  assign h_valid_s = tag_r[DEPTH-1][VLD_BIT];
  assign h_id_s    = tag_r[DEPTH-1][ID_LSB +: ID_W];
  assign h_rnd_s   = tag_r[DEPTH-1][TAG_RND_LSB +: RND_W];

  assign final_s  = h_valid_s && (h_rnd_s == LAST_RND);
  assign retire_s = final_s && bus.done_rdy && !reset;
  assign free_s   = !h_valid_s || (final_s && bus.done_rdy);
  assign arb_en_s = free_s && !reset;
  assign inj_id_s = bus.req_id[int'(gidx_s)*ID_W +: ID_W];

  shreg_slot_sched_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .CLK     (CLK),
    .reset   (reset),
    .en      (arb_en_s),
    .req     (bus.req),
    .gnt     (gnt_s),
    .gidx    (gidx_s),
    .any_gnt (any_gnt_s)
  );

  // A final-pass head blocks the whole pipeline until the consumer takes it.
  always_comb begin
    if (reset) begin
      act_s = ACT_HOLD;
    end else if (final_s && !bus.done_rdy) begin
      act_s = ACT_HOLD;
    end else if (h_valid_s && !final_s) begin
      act_s = ACT_RECIRC;
    end else if (any_gnt_s) begin
      act_s = ACT_INJECT;
    end else begin
      act_s = ACT_BUBBLE;
    end
  end

  always_comb begin
    case (act_s)
      ACT_RECIRC: tail_s = {1'b1, h_id_s, h_rnd_s + RND_W'(1)};
      ACT_INJECT: tail_s = {1'b1, inj_id_s, {RND_W{1'b0}}};
      default:    tail_s = '0;
    endcase
  end

  // Data shreg contents are never reset; clearing the tags masks them.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) tag_r[i] <= '0;
    end else if (act_s != ACT_HOLD) begin
      tag_r[0] <= tail_s;
      for (int i = 1; i < DEPTH; i++) tag_r[i] <= tag_r[i-1];
    end else begin
      for (int i = 0; i < DEPTH; i++) tag_r[i] <= tag_r[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      occ_r <= '0;
    end else if (act_s != ACT_HOLD) begin
      occ_r <= occ_r + OCC_W'(act_s == ACT_INJECT) - OCC_W'(retire_s);
    end else begin
      occ_r <= occ_r;
    end
  end

  assign done_valid_s   = final_s && !reset;
  assign bus.gnt        = gnt_s;
  assign bus.shreg_en   = (act_s != ACT_HOLD);
  assign bus.mux_sel    = (act_s == ACT_RECIRC);
  assign bus.done_valid = done_valid_s;
  assign bus.done_id    = done_valid_s ? h_id_s : {ID_W{1'b0}};
  assign bus.occupancy  = reset ? {OCC_W{1'b0}} : occ_r;
  assign bus.busy       = !reset && (occ_r != {OCC_W{1'b0}});

endmodule

// File: doc/shreg_slot_sched.md
Name: shreg_slot_sched

Overview:
- Scheduler for one shared interleaved pipeline built from shreg delay lines inside the sha512crypt core.
- The pipeline holds DEPTH slots; each slot carries one context's state and takes ROUNDS passes through the loop.
- The block keeps a tag line in lockstep with the data shreg and drives the shreg enable and the input mux (new data vs recirculate).
- It arbitrates N_REQ requesters round-robin into free slots and retires finished contexts over a valid/ready handshake.

Parameters:
- DEPTH, 4, pipeline slots; equals the shreg DEPTH; legal range 1..16.
- ROUNDS, 3, passes per context before retire; legal range 1..2^RND_W.
- N_REQ, 2, number of requesters; legal range 1..8.
- ID_W, 3, width of the context/owner id.
- RND_W, 8, width of the per-slot round counter.

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  requester wants to inject a context; held until granted
- req_id  in  N_REQ*ID_W  context id per requester
- gnt  out  N_REQ  one-hot grant, combinational in the same cycle; the granted requester's data is muxed in that cycle
- shreg_en  out  1  enable to all data shreg instances
- mux_sel  out  1  0 = load requester data, 1 = recirculate the shreg output
- done_valid  out  1  head slot is on its final pass
- done_id  out  ID_W  id of the retiring context
- done_rdy  in  1  consumer accepts the retiring context
- occupancy  out  5  number of valid slots (0..DEPTH)
- busy  out  1  occupancy != 0

Behaviour:
- Tag line: DEPTH-entry shift of {valid, id, round}, advanced only when shreg_en=1. The head entry aligns with shreg output o.
- Reset (synchronous): all tags are invalid, the round-robin pointer is 0, and occupancy is 0.
  - During reset: gnt=0, shreg_en=0, mux_sel=0, done_valid=0, done_id=0, busy=0.
  - Data shreg contents are not reset; invalid tags mask them.
- Reset mid-operation: in-flight contexts are dropped silently; no done is issued for them.
- Per-cycle decision when not in reset, evaluated on the head tag H:
  - H.valid and H.round==ROUNDS-1: done_valid=1, done_id=H.id.
    - If done_rdy=0: stall. shreg_en=0, gnt=0, no state change.
    - If done_rdy=1: shreg_en=1, and the slot is free for injection this cycle.
  - H.valid and H.round<ROUNDS-1: recirculate. shreg_en=1, mux_sel=1, gnt=0. The tail tag gets {1, H.id, H.round+1}.
  - H invalid, or retiring with done_rdy=1: free slot.
    - If any req: grant round-robin starting at ptr. mux_sel=0, shreg_en=1, tail tag {1, req_id[g], 0}, ptr <= g+1 mod N_REQ.
    - If no req: shreg_en=1 and a bubble is inserted (tail valid=0). The pipeline always advances unless stalled.
- Latency: a context granted on enabled cycle t retires DEPTH*ROUNDS enabled cycles later. Stall cycles add 1:1.
- ROUNDS=1: a context is injected with round 0 and is already final at the head after DEPTH enables.
- occupancy:
  - +1 on inject, −1 on retire.
  - Retire and inject in the same cycle leave it unchanged.
  - Never exceeds DEPTH; when full, injection occurs only in the retire-and-inject case.
- gnt is at most one-hot. A requester whose req is asserted for N_REQ*DEPTH*ROUNDS cycles is guaranteed a grant (round-robin fairness).
- done_valid is a function of registered state only. done_id is stable while done_valid=1 and done_rdy=0.

Decomposition:
- Shared package/header holds:
  - tag field widths and tag-pack offsets (valid, id, round);
  - DEPTH/ROUNDS limits;
  - the occupancy width constant.
- Sub-module rr_arbiter (N_REQ one-hot round-robin with pointer update on accept) is instantiated once.
- Tag line: a plain register array, or shreg of width 1+ID_W+RND_W with the same shreg_en.

Test Plan (all with DEPTH=4, ROUNDS=3, N_REQ=2, ID_W=3):
- Reset, then no req for 10 cycles -> shreg_en=1 every cycle, gnt=0, done_valid=0, occupancy=0.
- req[0] pulse with id 5 at cycle t, done_rdy=1 -> gnt=01 at t; mux_sel=1 at t+4 and t+8; done_valid with done_id=5 at t+12; occupancy back to 0 at t+13.
- req=11 held, ids 1/2, done_rdy=1 -> grants alternate 01,10,01,10 into the 4 slots; no further grants until the first retire at +12, which injects in the same cycle with occupancy steady at 4.
- Context at head on its final pass with done_rdy=0 for 3 cycles -> shreg_en=0, gnt=0, done_id stable for 3 cycles; on done_rdy=1, retire and the pipeline resumes; total latency 15.
- Assert reset with 3 contexts in flight -> no done_valid afterwards, occupancy=0, next req granted with round 0.
- ROUNDS=1 build, req id 7 -> done_valid with id 7 exactly 4 enabled cycles after grant, mux_sel never 1.
